// File: rtl/exception_ctrl.sv
// CP0 exception/interrupt controller: cause priority, EPC/BadVAddr capture,
// Count/Compare timer and ERET return, committed from the memory stage.
module exception_ctrl #(
    parameter int          NUM_HW_INT  = 6,
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_m,
    input  logic                  valid_m,
    input  logic                  ri,
    input  logic                  brk,
    input  logic                  sys,
    input  logic                  ov,
    input  logic                  adel,
    input  logic                  ades,
    input  logic                  pc_err,
    input  logic                  eret,
    input  logic                  in_ds_m,
    input  logic [31:0]           pc_m,
    input  logic [31:0]           alu_out_m,
    input  logic [NUM_HW_INT-1:0] hw_int,
    input  logic                  cp0_we,
    input  logic [4:0]            cp0_waddr,
    input  logic [31:0]           cp0_wdata,
    input  logic [4:0]            cp0_raddr,
    output logic [31:0]           cp0_rdata,
    output logic                  flush,
    output logic [31:0]           pc_target,
    output logic [4:0]            exc_code,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic                  timer_int
);

    localparam logic [4:0] A_BADV = 5'd8;
    localparam logic [4:0] A_CNT  = 5'd9;
    localparam logic [4:0] A_CMP  = 5'd11;
    localparam logic [4:0] A_STAT = 5'd12;
    localparam logic [4:0] A_CAUS = 5'd13;
    localparam logic [4:0] A_EPC  = 5'd14;

    localparam logic [4:0] C_INT  = 5'h00;
    localparam logic [4:0] C_ADEL = 5'h04;
    localparam logic [4:0] C_ADES = 5'h05;
    localparam logic [4:0] C_SYS  = 5'h08;
    localparam logic [4:0] C_BP   = 5'h09;
    localparam logic [4:0] C_RI   = 5'h0A;
    localparam logic [4:0] C_OV   = 5'h0C;

    logic [NUM_HW_INT-1:0] sync_q [SYNC_STAGES];
    logic [7:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_q;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        toggle;
    logic        timer_q;

    logic [5:0]  hw_vec;
    logic        int_pend;
    logic        exc_hit;
    logic [4:0]  exc_sel;
    logic        commit;
    logic        exc_take;
    logic        eret_take;
    logic        wr_cnt;
    logic        wr_cmp;
    logic        wr_stat;
    logic        wr_caus;
    logic        wr_epc;

    assign int_pend = valid_m & ie & ~exl & (|(im & {ip_hw, ip_sw}));

    always_comb begin
        exc_hit = 1'b1;
        exc_sel = C_INT;
        if (int_pend)            exc_sel = C_INT;
        else if (adel | pc_err)  exc_sel = C_ADEL;
        else if (ri)             exc_sel = C_RI;
        else if (sys)            exc_sel = C_SYS;
        else if (brk)            exc_sel = C_BP;
        else if (ades)           exc_sel = C_ADES;
        else if (ov)             exc_sel = C_OV;
        else                     exc_hit = 1'b0;
    end

    // rst gating keeps the reset cycle from committing anything
    assign commit    = rst & valid_m & ~stall_m & (exc_hit | eret);
    assign exc_take  = commit & exc_hit;
    assign eret_take = commit & ~exc_hit;

    assign flush     = commit;
    assign pc_target = exc_take ? EXC_VECTOR : (eret_take ? epc : 32'h0);
    assign exc_code  = exc_take ? exc_sel : (eret_take ? 5'h1F : 5'h00);

    assign wr_cnt  = cp0_we & (cp0_waddr == A_CNT);
    assign wr_cmp  = cp0_we & (cp0_waddr == A_CMP);
    assign wr_stat = cp0_we & (cp0_waddr == A_STAT);
    assign wr_caus = cp0_we & (cp0_waddr == A_CAUS);
    assign wr_epc  = cp0_we & (cp0_waddr == A_EPC);

    always_comb begin
        hw_vec = '0;
        hw_vec[NUM_HW_INT-1:0] = sync_q[SYNC_STAGES-1];
        hw_vec[5] = hw_vec[5] | timer_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= hw_int;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip_hw    <= '0;
            ip_sw    <= '0;
            exc_q    <= '0;
            epc      <= '0;
            badvaddr <= '0;
            count    <= '0;
            compare  <= '0;
            toggle   <= 1'b0;
            timer_q  <= 1'b0;
        end else begin
            ip_hw <= hw_vec;

            if (wr_cnt) begin
                count  <= cp0_wdata;
                toggle <= 1'b0;
            end else begin
                toggle <= ~toggle;
                if (toggle) count <= count + 32'd1;
            end

            if (wr_cmp) compare <= cp0_wdata;
            if (wr_cmp)                    timer_q <= 1'b0;
            else if (count == compare)     timer_q <= 1'b1;

            // exception commit owns Status/Cause/EPC this cycle
            if (exc_take) begin
                exl   <= 1'b1;
                exc_q <= exc_sel;
                if (!exl) begin
                    epc <= in_ds_m ? pc_m - 32'd4 : pc_m;
                    bd  <= in_ds_m;
                end
                if (exc_sel == C_ADEL)
                    badvaddr <= pc_err ? pc_m : alu_out_m;
                else if (exc_sel == C_ADES)
                    badvaddr <= alu_out_m;
            end else begin
                if (eret_take) begin
                    exl <= 1'b0;
                end else if (wr_stat) begin
                    im  <= cp0_wdata[15:8];
                    exl <= cp0_wdata[1];
                    ie  <= cp0_wdata[0];
                end
                if (wr_caus) ip_sw <= cp0_wdata[9:8];
                if (wr_epc)  epc   <= cp0_wdata;
            end
        end
    end

    assign status_o  = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    assign cause_o   = {bd, 15'b0, ip_hw, ip_sw, 1'b0, exc_q, 2'b0};
    assign epc_o     = epc;
    assign timer_int = timer_q;

    always_comb begin
        case (cp0_raddr)
            A_BADV:  cp0_rdata = badvaddr;
            A_CNT:   cp0_rdata = count;
            A_CMP:   cp0_rdata = compare;
            A_STAT:  cp0_rdata = status_o;
            A_CAUS:  cp0_rdata = cause_o;
            A_EPC:   cp0_rdata = epc;
            default: cp0_rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Random and directed stimulus for exception_ctrl, compared every cycle
// against a cycle-count based CP0 reference model.
module tb_exception_ctrl;

    localparam int NHW  = 6;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst;
    logic stall_m, valid_m, ri, brk, sys, ov, adel, ades, pc_err, eret;
    logic in_ds_m;
    logic [31:0] pc_m, alu_out_m;
    logic [NHW-1:0] hw_int;
    logic cp0_we;
    logic [4:0] cp0_waddr, cp0_raddr;
    logic [31:0] cp0_wdata, cp0_rdata;
    logic flush;
    logic [31:0] pc_target;
    logic [4:0] exc_code;
    logic [31:0] status_o, cause_o, epc_o;
    logic timer_int;

    exception_ctrl #(
        .NUM_HW_INT(NHW),
        .EXC_VECTOR(32'hBFC0_0380),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .stall_m(stall_m), .valid_m(valid_m),
        .ri(ri), .brk(brk), .sys(sys), .ov(ov), .adel(adel),
        .ades(ades), .pc_err(pc_err), .eret(eret), .in_ds_m(in_ds_m),
        .pc_m(pc_m), .alu_out_m(alu_out_m), .hw_int(hw_int),
        .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
        .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .flush(flush),
        .pc_target(pc_target), .exc_code(exc_code),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
        .timer_int(timer_int)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_bad, m_cbase, m_cmp;
    int unsigned m_ccyc;
    logic        m_timer, m_tprev;
    logic [5:0]  hq[$];

    logic        last_flush;
    logic [4:0]  last_code;
    logic [31:0] last_target;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        stall_m = 0; valid_m = 0; ri = 0; brk = 0; sys = 0; ov = 0;
        adel = 0; ades = 0; pc_err = 0; eret = 0; in_ds_m = 0;
        pc_m = 32'h8000_0000; alu_out_m = 32'h0;
        cp0_we = 0; cp0_waddr = 0; cp0_wdata = 0; cp0_raddr = 5'd12;
    endtask

    task automatic model_reset();
        m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ipsw = 0; m_exc = 0;
        m_epc = 0; m_bad = 0; m_cbase = 0; m_cmp = 0; m_ccyc = 0;
        m_timer = 0; m_tprev = 0;
        hq.delete();
        repeat (SYNC + 1) hq.push_back(6'h0);
    endtask

    task automatic cycle();
        logic [5:0]  iphw, pad;
        logic [7:0]  ip;
        logic        pend, ehit, take_e, take_r, nt;
        logic [4:0]  code;
        logic [31:0] cnt, e_stat, e_caus, e_rd, e_tgt, e_code;
        @(negedge clk);
        cnt  = m_cbase + 32'(m_ccyc >> 1);
        iphw = hq[SYNC] | {m_tprev, 5'b0};
        ip   = {iphw, m_ipsw};
        pend = valid_m & m_ie & ~m_exl & (|(m_im & ip));
        ehit = 1'b1;
        code = 5'h00;
        if (pend)                code = 5'h00;
        else if (adel | pc_err)  code = 5'h04;
        else if (ri)             code = 5'h0A;
        else if (sys)            code = 5'h08;
        else if (brk)            code = 5'h09;
        else if (ades)           code = 5'h05;
        else if (ov)             code = 5'h0C;
        else                     ehit = 1'b0;
        take_e = valid_m & ~stall_m & ehit;
        take_r = valid_m & ~stall_m & ~ehit & eret;
        e_tgt  = take_e ? 32'hBFC0_0380 : (take_r ? m_epc : 32'h0);
        e_code = take_e ? 32'(code) : (take_r ? 32'h1F : 32'h0);
        e_stat = {9'b0, 1'b1, 6'b0, m_im, 6'b0, m_exl, m_ie};
        e_caus = {m_bd, 15'b0, iphw, m_ipsw, 1'b0, m_exc, 2'b0};
        case (cp0_raddr)
            5'd8:    e_rd = m_bad;
            5'd9:    e_rd = cnt;
            5'd11:   e_rd = m_cmp;
            5'd12:   e_rd = e_stat;
            5'd13:   e_rd = e_caus;
            5'd14:   e_rd = m_epc;
            default: e_rd = 32'h0;
        endcase
        check("flush", flush, take_e | take_r);
        check("pc_target", pc_target, e_tgt);
        check("exc_code", exc_code, e_code);
        check("status", status_o, e_stat);
        check("cause", cause_o, e_caus);
        check("epc", epc_o, m_epc);
        check("timer_int", timer_int, m_timer);
        check("rdata", cp0_rdata, e_rd);
        last_flush  = flush;
        last_code   = exc_code;
        last_target = pc_target;
        @(posedge clk);
        #1;
        if (cp0_we && cp0_waddr == 5'd11) nt = 1'b0;
        else if (cnt == m_cmp)            nt = 1'b1;
        else                              nt = m_timer;
        m_tprev = m_timer;
        m_timer = nt;
        pad = '0;
        pad[NHW-1:0] = hw_int;
        hq.push_front(pad);
        void'(hq.pop_back());
        if (cp0_we && cp0_waddr == 5'd9) begin
            m_cbase = cp0_wdata;
            m_ccyc  = 0;
        end else begin
            m_ccyc++;
        end
        if (cp0_we && cp0_waddr == 5'd11) m_cmp = cp0_wdata;
        if (take_e) begin
            if (!m_exl) begin
                m_epc = in_ds_m ? pc_m - 32'd4 : pc_m;
                m_bd  = in_ds_m;
            end
            m_exl = 1'b1;
            m_exc = code;
            if (code == 5'h04)      m_bad = pc_err ? pc_m : alu_out_m;
            else if (code == 5'h05) m_bad = alu_out_m;
        end else begin
            if (take_r) begin
                m_exl = 1'b0;
            end else if (cp0_we && cp0_waddr == 5'd12) begin
                m_im  = cp0_wdata[15:8];
                m_exl = cp0_wdata[1];
                m_ie  = cp0_wdata[0];
            end
            if (cp0_we && cp0_waddr == 5'd13) m_ipsw = cp0_wdata[9:8];
            if (cp0_we && cp0_waddr == 5'd14) m_epc  = cp0_wdata;
        end
    endtask

    task automatic mtc0(logic [4:0] a, logic [31:0] d);
        idle();
        cp0_we = 1; cp0_waddr = a; cp0_wdata = d;
        cycle();
        idle();
    endtask

    task automatic rand_inputs();
        logic [4:0] addrs [7];
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
        valid_m = ($urandom_range(0, 3) != 0);
        stall_m = ($urandom_range(0, 4) == 0);
        ri      = ($urandom_range(0, 15) == 0);
        brk     = ($urandom_range(0, 15) == 0);
        sys     = ($urandom_range(0, 15) == 0);
        ov      = ($urandom_range(0, 15) == 0);
        adel    = ($urandom_range(0, 15) == 0);
        ades    = ($urandom_range(0, 15) == 0);
        pc_err  = ($urandom_range(0, 15) == 0);
        eret    = ($urandom_range(0, 7) == 0);
        in_ds_m = ($urandom_range(0, 3) == 0);
        pc_m      = $urandom;
        alu_out_m = $urandom;
        if ($urandom_range(0, 19) == 0) hw_int = NHW'($urandom);
        cp0_we    = ($urandom_range(0, 5) == 0);
        cp0_waddr = addrs[$urandom_range(0, 6)];
        cp0_wdata = $urandom;
        cp0_raddr = addrs[$urandom_range(0, 6)];
    endtask

    initial begin
        int lat;
        int tfirst;
        logic [31:0] old_epc;
        idle();
        hw_int = '0;
        rst = 1'b0;
        valid_m = 1; sys = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_status", status_o, 32'h0040_0000);
        check("rst_cause", cause_o, 32'h0);
        check("rst_epc", epc_o, 32'h0);
        check("rst_flush", flush, 1'b0);
        check("rst_target", pc_target, 32'h0);
        check("rst_code", exc_code, 5'h0);
        check("rst_timer", timer_int, 1'b0);
        rst = 1'b1;
        idle();
        model_reset();

        mtc0(5'd12, 32'h0000_0401);
        hw_int = 1; valid_m = 1;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (last_flush) break;
            lat++;
        end
        check("int_latency", lat, SYNC + 1);
        check("int_target", last_target, 32'hBFC0_0380);
        check("int_code", last_code, 5'h00);
        check("int_exl", status_o[1], 1'b1);
        hw_int = 0; valid_m = 0;
        repeat (SYNC + 2) cycle();
        mtc0(5'd12, 32'h0);

        valid_m = 1; pc_m = 32'h8000_1004; in_ds_m = 1; ov = 1;
        cycle();
        idle();
        check("ds_epc", epc_o, 32'h8000_1000);
        check("ds_bd", cause_o[31], 1'b1);
        check("ds_exccode", cause_o[6:2], 5'h0C);
        mtc0(5'd12, 32'h0);

        valid_m = 1; pc_err = 1; ri = 1; pc_m = 32'h8000_0002;
        cycle();
        check("pcerr_code", last_code, 5'h04);
        idle();
        cp0_raddr = 5'd8;
        #1;
        check("pcerr_badv", cp0_rdata, 32'h8000_0002);
        mtc0(5'd12, 32'h0);

        valid_m = 1; brk = 1; stall_m = 1; pc_m = 32'h8000_2000;
        cycle();
        check("stall_flush", last_flush, 1'b0);
        stall_m = 0;
        cycle();
        check("bp_flush", last_flush, 1'b1);
        check("bp_code", last_code, 5'h09);
        idle();

        old_epc = epc_o;
        valid_m = 1; sys = 1; pc_m = 32'h8000_3000;
        cycle();
        check("nest_flush", last_flush, 1'b1);
        check("nest_epc", epc_o, old_epc);
        idle();
        valid_m = 1; eret = 1;
        cycle();
        check("eret_target", last_target, old_epc);
        check("eret_exl", status_o[1], 1'b0);
        idle();

        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd0);
        tfirst = -1;
        for (int i = 1; i <= 30; i++) begin
            cycle();
            if (timer_int && tfirst < 0) tfirst = i;
        end
        check("timer_delay", tfirst, 21);
        mtc0(5'd11, 32'd50);
        check("timer_clear", timer_int, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
